// File: rtl/sync_down_counter_if.sv
// Control/status bundle for sync_down_counter: load/enable requests in, count and flags out.
interface sync_down_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  // Requester side (software/FSM driving the timer)
  modport master (
    output load, load_val, en,
    input  q, tc, busy
  );

  // Counter side
  modport slave (
    input  load, load_val, en,
    output q, tc, busy
  );

endinterface

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter with a one-cycle terminal-count pulse.
// Optional feature macro: SYNC_DOWN_CNT_RELOAD_EN -- when defined, the terminal
// decrement reloads the last loaded start value and keeps running (periodic tc);
// when undefined, the counter is one-shot and parks in IDLE at zero.
module sync_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_down_counter_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

`ifdef SYNC_DOWN_CNT_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state and next-output logic: load > count > hold
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
`ifdef SYNC_DOWN_CNT_RELOAD_EN
    reload_d = reload_q;
`endif

    if (bus.load) begin
      q_d     = bus.load_val;
      state_d = (bus.load_val != '0) ? RUN : IDLE;
`ifdef SYNC_DOWN_CNT_RELOAD_EN
      reload_d = bus.load_val;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (bus.en) begin
            if (q_q > WIDTH'(1)) begin
              q_d = q_q - WIDTH'(1);
            end else begin
              // Terminal decrement; q==0 cannot occur in RUN, guarded anyway
              tc_d = (q_q == WIDTH'(1));
`ifdef SYNC_DOWN_CNT_RELOAD_EN
              q_d     = reload_q;
              state_d = (reload_q != '0) ? RUN : IDLE;
`else
              q_d     = '0;
              state_d = IDLE;
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SYNC_DOWN_CNT_RELOAD_EN
  // Start value retained for periodic reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign bus.q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule
